// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_ctrl_pkg
// Description : Shared UART controller definitions. Holds the FIFO trigger
//               level encoding and its decode table, used by both the TX
//               and RX FIFOs.
// Contents    : trig_sel_e  - 2-bit trigger level select
//               trig_level  - decode of trig_sel_e to an entry count,
//                             clamped to the FIFO depth
// Revision    : 1.0 - initial release
// ============================================================================
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    TRIG_1  = 2'b00,
    TRIG_4  = 2'b01,
    TRIG_8  = 2'b10,
    TRIG_14 = 2'b11
  } trig_sel_e;

  // Small FIFOs cannot reach 8 or 14 entries, so clamp to DEPTH so that the
  // trigger still fires when the FIFO is full.
  function automatic int unsigned trig_level(input trig_sel_e sel,
                                             input int unsigned depth);
    int unsigned lvl;
    case (sel)
      TRIG_1:  lvl = 1;
      TRIG_4:  lvl = 4;
      TRIG_8:  lvl = 8;
      default: lvl = 14;
    endcase
    return (lvl > depth) ? depth : lvl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_ctrl_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_ctrl_fifo_mem
// Description : DEPTH x WIDTH register array with one synchronous write port
//               and one asynchronous read port. Contents are not reset.
// Ports       : clock      - write clock
//               wr_en_i    - write enable
//               wr_addr_i  - write address
//               wr_data_i  - write data
//               rd_addr_i  - read address
//               rd_data_o  - read data, combinational from rd_addr_i
// Revision    : 1.0 - initial release
// ============================================================================
module uart_ctrl_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/uart_ctrl_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_ctrl_tx_fifo
// Description : UART transmit FIFO, first-word fall-through. Occupancy is
//               tracked by a registered level counter from which full/empty
//               are decoded. Registered trigger flag, sticky overrun and
//               underrun flags, synchronous flush.
// Ports       : clock     - single clock, rising edge
//               reset_n   - asynchronous active-low reset
//               push      - write request, wr_data sampled with it
//               wr_data   - write data
//               pop       - read request from the shift stage
//               fifo_clr  - synchronous flush, overrides push/pop
//               trig_sel  - trigger level select (1/4/8/14 entries)
//               rd_data   - head entry
//               full      - level == DEPTH
//               empty     - level == 0
//               level     - occupancy 0..DEPTH
//               trig      - registered, level >= selected trigger level
//               overrun   - sticky, push while full
//               underrun  - sticky, pop while empty
// Revision    : 1.0 - initial release
// ============================================================================
module uart_ctrl_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  input  logic                     fifo_clr,
  input  logic [1:0]               trig_sel,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     trig,
  output logic                     overrun,
  output logic                     underrun
);

  import uart_ctrl_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          trig_q, trig_d;
  logic          overrun_q, overrun_d;
  logic          underrun_q, underrun_d;

  logic          full_w;
  logic          empty_w;
  logic          do_push_w;
  logic          do_pop_w;
  logic          mem_we_w;
  logic [LW-1:0] trig_thresh_w;

  assign full_w  = (level_q == LW'(DEPTH));
  assign empty_w = (level_q == '0);

  // A pop at full frees the slot the push needs, so both proceed. A push at
  // empty makes the pop see nothing yet, so only the push proceeds.
  assign do_push_w = push && (!full_w || pop);
  assign do_pop_w  = pop && !empty_w;
  assign mem_we_w  = do_push_w && !fifo_clr;

  assign trig_thresh_w = LW'(trig_level(trig_sel_e'(trig_sel), DEPTH));

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    trig_d     = (level_q >= trig_thresh_w);
    overrun_d  = overrun_q;
    underrun_d = underrun_q;

    if (fifo_clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      trig_d     = 1'b0;
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end else begin
      if (do_push_w) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop_w) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      level_d = level_q + LW'(do_push_w) - LW'(do_pop_w);
      if (push && full_w && !pop) begin
        overrun_d = 1'b1;
      end
      if (pop && empty_w && !push) begin
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      trig_q     <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      trig_q     <= trig_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  uart_ctrl_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clock     (clock),
    .wr_en_i   (mem_we_w),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  assign full     = full_w;
  assign empty    = empty_w;
  assign level    = level_q;
  assign trig     = trig_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_ctrl_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_ctrl_tx_fifo
// Description : Self-checking bench for uart_ctrl_tx_fifo (DEPTH=16,
//               WIDTH=8). Stimulus queues the data it expects to come out;
//               a monitor pops and compares whenever an entry is read.
//               Status outputs are compared against hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_ctrl_tx_fifo;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       push;
  logic [7:0] wr_data;
  logic       pop;
  logic       fifo_clr;
  logic [1:0] trig_sel;
  logic [7:0] rd_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       trig;
  logic       overrun;
  logic       underrun;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];

  always #5 clock = ~clock;

  uart_ctrl_tx_fifo #(
    .DEPTH (16),
    .WIDTH (8)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .wr_data  (wr_data),
    .pop      (pop),
    .fifo_clr (fifo_clr),
    .trig_sel (trig_sel),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .trig     (trig),
    .overrun  (overrun),
    .underrun (underrun)
  );

  // Monitor: an entry is delivered when pop is asserted on a non-empty FIFO.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && pop === 1'b1 && empty === 1'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_data: got %0h, expected no entry", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_fail++;
          $display("FAIL rd_data: got %0h, expected %0h", rd_data, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; queue_it records the data as expected output.
  task automatic step(input logic p, input logic [7:0] d, input logic q,
                      input logic c, input logic queue_it);
    push     = p;
    wr_data  = d;
    pop      = q;
    fifo_clr = c;
    if (queue_it) exp_q.push_back(d);
    @(posedge clock);
    #1;
    push     = 1'b0;
    pop      = 1'b0;
    fifo_clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    push     = 1'b0;
    wr_data  = 8'h00;
    pop      = 1'b0;
    fifo_clr = 1'b0;
    trig_sel = 2'b00;

    #2;
    check("reset_level", 32'(level), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    check("reset_trig", 32'(trig), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_underrun", 32'(underrun), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
      check("fill_level", 32'(level), 32'(i + 1));
      check("fill_rd_data", 32'(rd_data), 32'h00);
    end
    check("fill_full", 32'(full), 32'd1);

    // Overrun: push while full is dropped
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_level", 32'(level), 32'd16);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_level", 32'(level), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Underrun: pop while empty is ignored
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("udr_flag", 32'(underrun), 32'd1);
    check("udr_level", 32'(level), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("clr_overrun", 32'(overrun), 32'd0);
    check("clr_underrun", 32'(underrun), 32'd0);

    // Wrap: push 10, pop 10, push 12, pop 12
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b1);
    check("wrap_level12", 32'(level), 32'd12);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("wrap_level0", 32'(level), 32'd0);
    check("wrap_empty", 32'(empty), 32'd1);

    // Simultaneous push+pop at level 0, 5 and 16
    step(1'b1, 8'h60, 1'b1, 1'b0, 1'b1);
    check("sim0_level", 32'(level), 32'd1);
    check("sim0_underrun", 32'(underrun), 32'd0);
    for (int i = 1; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h65, 1'b1, 1'b0, 1'b1);
    check("sim5_level", 32'(level), 32'd5);
    for (int i = 6; i < 17; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b1);
    check("sim16_full", 32'(full), 32'd1);
    step(1'b1, 8'h71, 1'b1, 1'b0, 1'b1);
    check("sim16_level", 32'(level), 32'd16);
    check("sim16_overrun", 32'(overrun), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    exp_q.delete();
    check("flush_empty", 32'(empty), 32'd1);

    // Trigger at 8 entries, one-cycle latency
    trig_sel = 2'b10;
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("trig_at7", 32'(trig), 32'd0);
    step(1'b1, 8'h87, 1'b0, 1'b0, 1'b1);
    check("trig_lvl8_lat", 32'(trig), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("trig_at8", 32'(trig), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("trig_pop_lat", 32'(trig), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("trig_at7b", 32'(trig), 32'd0);
    trig_sel = 2'b01;
    #1;
    check("trig_sel_lat", 32'(trig), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("trig_sel4", 32'(trig), 32'd1);

    // Flush at level 9 with overrun set, push in the same cycle
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h88 + i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("pre_clr_level", 32'(level), 32'd9);
    check("pre_clr_overrun", 32'(overrun), 32'd1);
    step(1'b1, 8'hEF, 1'b0, 1'b1, 1'b0);
    exp_q.delete();
    check("clr_level", 32'(level), 32'd0);
    check("clr_overrun2", 32'(overrun), 32'd0);
    check("clr_trig", 32'(trig), 32'd0);

    // Reset during a push
    step(1'b1, 8'hC0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b1);
    push    = 1'b1;
    wr_data = 8'hC2;
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_empty", 32'(empty), 32'd1);
    check("rst_mid_level", 32'(level), 32'd0);
    push = 1'b0;
    exp_q.delete();
    @(posedge clock);
    #1 reset_n = 1'b1;
    step(1'b1, 8'hD0, 1'b0, 1'b0, 1'b1);
    check("rst_slot0", 32'(rd_data), 32'hD0);
    check("rst_push_level", 32'(level), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("final_empty", 32'(empty), 32'd1);
    check("all_entries_seen", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
